uart_tx: RTL

UART transmitter. It serialises 8-bit words onto a single line as 8N1 frames (start 0, 8 data bits LSB first, stop 1). Its bit timing matches our receiver (uart_rx) in loopback.
It sits between the host-side byte producer and the tx pad. A one-entry holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_tx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and line constants
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake between the host producer and uart_tx
interface uart_tx_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit period counter with terminal-count tick
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == TERM);

  // Count 0..CLKS_PER_BIT-1, wrapping at terminal count; clear holds it at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-entry holding register
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave in_if,
  output logic     tx,
  output logic     tx_busy,
  output logic     send_finish
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        finish_q, finish_d;

  logic bit_tick;
  logic timer_clear;
  logic accept;
  logic take_direct;

  // The timer only runs while a frame is on the line, so every frame starts at count 0
  assign timer_clear = (state_q == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (bit_tick)
  );

  // Ready depends only on the holding register, never on in_valid
  assign in_if.in_ready = !hold_full_q;
  assign accept         = in_if.in_valid && !hold_full_q;

  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign send_finish = finish_q;

  // Next-state: frame sequencing, shift register, holding register and registered outputs
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_idx_d   = bit_idx_q;
    finish_d    = 1'b0;
    take_direct = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          take_direct = 1'b1;
          shift_d     = in_if.in_data;
          bit_idx_d   = '0;
          state_d     = START;
        end
      end
      START: begin
        if (bit_tick) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_idx_q == LAST_STOP) begin
            finish_d  = 1'b1;
            bit_idx_d = '0;
            if (hold_full_q) begin
              // Back-to-back: held word goes straight out with no idle gap
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              state_d     = START;
            end else if (accept) begin
              // A word arriving on the closing edge also skips the holding register
              take_direct = 1'b1;
              shift_d     = in_if.in_data;
              state_d     = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept && !take_direct) begin
      hold_d      = in_if.in_data;
      hold_full_d = 1'b1;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = LINE_IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops the frame and any held word at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      tx_q        <= LINE_IDLE;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
    end
  end

endmodule
